// File: rtl/wb_port_arbiter.sv
// ---------------------------------------------------------------------------
// wb_port_arbiter
//
// Shares the register file's single write port among NUM_REQ writeback
// sources. Each cycle one valid requester is granted by round-robin and its
// rd/data are registered onto the write-port outputs (latency 1). Requesters
// that are not granted see ready low and keep their request pending.
//
// Optional feature (macro WB_ARB_PERF_EN): adds a saturating 32-bit counter
// of cycles in which at least one valid request was left waiting.
//
// Ports:
//   clk_i          clock, rising edge
//   n_rst          asynchronous active-low reset
//   req_valid_i    per-requester write request
//   req_rd_i       packed destination addresses, requester i at [i*AW +: AW]
//   req_wd_i       packed write data, requester i at [i*XLEN +: XLEN]
//   req_ready_o    one-hot grant, request consumed when valid & ready
//   wb_stall_i     freeze, no grants while high
//   rf_we_o        register-file write enable
//   rf_rd_addr_o   register-file destination address
//   rf_wd_o        register-file write data
//   grant_idx_o    requester that produced the current rf_* values
//   conflict_cnt_o waiting-request cycle counter (WB_ARB_PERF_EN only)
// ---------------------------------------------------------------------------
module wb_port_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = 32,
    parameter int AW      = 5
) (
    input  logic                      clk_i,
    input  logic                      n_rst,
    input  logic [NUM_REQ-1:0]        req_valid_i,
    input  logic [NUM_REQ*AW-1:0]     req_rd_i,
    input  logic [NUM_REQ*XLEN-1:0]   req_wd_i,
    output logic [NUM_REQ-1:0]        req_ready_o,
    input  logic                      wb_stall_i,
    output logic                      rf_we_o,
    output logic [AW-1:0]             rf_rd_addr_o,
    output logic [XLEN-1:0]           rf_wd_o,
    output logic [$clog2(NUM_REQ)-1:0] grant_idx_o
`ifdef WB_ARB_PERF_EN
    ,
    output logic [31:0]               conflict_cnt_o
`endif
);

    localparam int IDXW = $clog2(NUM_REQ);

    // NUM_REQ expressed in the one-bit-wider arithmetic used for the wrap,
    // so the modulo compare stays width-matched.
    localparam logic [IDXW:0] NREQ_W = (IDXW+1)'(NUM_REQ);

    logic [IDXW-1:0]    rr_ptr_q;
    logic [IDXW-1:0]    rr_ptr_d;
    logic               rf_we_q;
    logic [AW-1:0]      rf_addr_q;
    logic [XLEN-1:0]    rf_wd_q;
    logic [IDXW-1:0]    grant_idx_q;

    logic               grant_found;
    logic [IDXW-1:0]    grant_idx;
    logic [NUM_REQ-1:0] grant_oh;
    logic [IDXW:0]      cand;
    logic [IDXW:0]      ptr_inc;
    logic [AW-1:0]      sel_rd;
    logic [XLEN-1:0]    sel_wd;

    // Scan rr_ptr, rr_ptr+1, ... with an explicit wrap (NUM_REQ need not be
    // a power of two) and take the first valid requester.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand = {1'b0, rr_ptr_q} + (IDXW+1)'(off);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end
            if (!grant_found && !wb_stall_i && req_valid_i[cand[IDXW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDXW-1:0];
            end
        end
    end

    always_comb begin
        grant_oh = '0;
        if (grant_found) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    // Ready is held low while reset is asserted, independent of the inputs.
    assign req_ready_o = grant_oh & {NUM_REQ{n_rst}};

    assign sel_rd = req_rd_i[int'(grant_idx)*AW +: AW];
    assign sel_wd = req_wd_i[int'(grant_idx)*XLEN +: XLEN];

    // Pointer moves one past the granted index, wrapping at NUM_REQ.
    always_comb begin
        ptr_inc  = {1'b0, grant_idx} + (IDXW+1)'(1);
        rr_ptr_d = rr_ptr_q;
        if (grant_found) begin
            rr_ptr_d = (ptr_inc == NREQ_W) ? '0 : ptr_inc[IDXW-1:0];
        end
    end

    // Write-port register. A write to x0 is consumed but never enabled;
    // address/data/index still update so they show what was granted.
    always_ff @(posedge clk_i or negedge n_rst) begin
        if (!n_rst) begin
            rr_ptr_q    <= '0;
            rf_we_q     <= 1'b0;
            rf_addr_q   <= '0;
            rf_wd_q     <= '0;
            grant_idx_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            if (grant_found) begin
                rf_we_q     <= (sel_rd != '0);
                rf_addr_q   <= sel_rd;
                rf_wd_q     <= sel_wd;
                grant_idx_q <= grant_idx;
            end else begin
                rf_we_q     <= 1'b0;
            end
        end
    end

    assign rf_we_o      = rf_we_q;
    assign rf_rd_addr_o = rf_addr_q;
    assign rf_wd_o      = rf_wd_q;
    assign grant_idx_o  = grant_idx_q;

`ifdef WB_ARB_PERF_EN
    logic [31:0] conflict_cnt_q;

    // Counts cycles where some valid request was left waiting, whether it
    // lost arbitration or was frozen by the stall. Saturates at all-ones.
    always_ff @(posedge clk_i or negedge n_rst) begin
        if (!n_rst) begin
            conflict_cnt_q <= '0;
        end else if (|(req_valid_i & ~req_ready_o) && (conflict_cnt_q != 32'hFFFF_FFFF)) begin
            conflict_cnt_q <= conflict_cnt_q + 32'd1;
        end
    end

    assign conflict_cnt_o = conflict_cnt_q;
`endif

endmodule
